// File: rtl/ex_pkg.sv
// Shared types for the execute-result stage: ALU ops, condition codes,
// NZCV flags and the EX/MEM queue entry.
package ex_pkg;

  localparam int EX_DATA_W = 32;
  localparam int EX_RD_W   = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic [EX_DATA_W-1:0] result;
    logic [EX_RD_W-1:0]   rd_addr;
    logic                 reg_write;
  } ex_entry_t;

endpackage

// File: rtl/ex_result_stage_cond_check.sv
// Combinational condition-code evaluator: NZCV flags + condition -> taken.
module cond_check
  import ex_pkg::*;
(
  input  flags_t flags,
  input  cond_e  cond,
  output logic   taken
);

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      CC_EQ: taken = flags.z;
      CC_NE: taken = !flags.z;
      CC_CS: taken = flags.c;
      CC_CC: taken = !flags.c;
      CC_MI: taken = flags.n;
      CC_PL: taken = !flags.n;
      CC_VS: taken = flags.v;
      CC_VC: taken = !flags.v;
      CC_HI: taken = flags.c && !flags.z;
      CC_LS: taken = !flags.c || flags.z;
      CC_GE: taken = (flags.n == flags.v);
      CC_LT: taken = (flags.n != flags.v);
      CC_GT: taken = !flags.z && (flags.n == flags.v);
      CC_LE: taken = flags.z || (flags.n != flags.v);
      CC_AL: taken = 1'b1;
      CC_NV: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_result_stage.sv
// EX/MEM result stage: 2-entry skid queue, NZCV flag register, branch resolve.
// Optional EX_FLAGS_FWD_EN: branches that also set flags test their own new flags.
module ex_result_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = EX_DATA_W,
  parameter int RD_W   = EX_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_negative,
  input  logic [1:0]        alu_op,
  input  logic              set_flags,
  input  logic [RD_W-1:0]   rd_addr,
  input  logic              reg_write,
  input  logic              is_branch,
  input  logic [3:0]        branch_cond,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd_addr,
  output logic              out_reg_write,
  output logic [3:0]        flags_q,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_pc
);

  q_state_e          state_q, state_d;
  ex_entry_t         head_q, head_d, skid_q, skid_d, in_ent;
  logic              in_ready_q, in_ready_d;
  flags_t            nzcv_q, nzcv_d, nzcv_new, nzcv_eval;
  logic              bt_q, bt_d;
  logic [DATA_W-1:0] bpc_q, bpc_d;
  logic              acc, drn, cond_taken;

  assign acc = in_valid && in_ready_q && !flush;
  assign drn = (state_q != Q_EMPTY) && out_ready;

  always_comb begin
    in_ent     = '{result: alu_result, rd_addr: rd_addr, reg_write: reg_write};
    state_d    = state_q;
    head_d     = head_q;
    skid_d     = skid_q;
    if (flush) begin
      state_d = Q_EMPTY;
    end else begin
      unique case (state_q)
        Q_EMPTY: if (acc) begin
          head_d  = in_ent;
          state_d = Q_ONE;
        end
        Q_ONE: begin
          if (acc && drn) begin
            head_d = in_ent;
          end else if (acc) begin
            skid_d  = in_ent;
            state_d = Q_FULL;
          end else if (drn) begin
            state_d = Q_EMPTY;
          end
        end
        Q_FULL: if (drn) begin
          head_d  = skid_q;
          state_d = Q_ONE;
        end
        default: state_d = Q_EMPTY;
      endcase
    end
    // Registered ready: low exactly while the queue sits FULL.
    in_ready_d = (state_d != Q_FULL);
  end

  always_comb begin
    nzcv_new   = nzcv_q;
    nzcv_new.n = alu_negative;
    nzcv_new.z = alu_zero;
    if (alu_op_e'(alu_op) == OP_ADD || alu_op_e'(alu_op) == OP_SUB) begin
      nzcv_new.c = alu_carry;
      nzcv_new.v = alu_overflow;
    end
    nzcv_d = (acc && set_flags) ? nzcv_new : nzcv_q;
`ifdef EX_FLAGS_FWD_EN
    nzcv_eval = set_flags ? nzcv_new : nzcv_q;
`else
    nzcv_eval = nzcv_q;
`endif
    bt_d  = acc && is_branch && cond_taken;
    bpc_d = bt_d ? branch_target : bpc_q;
  end

  cond_check u_cond (
    .flags (nzcv_eval),
    .cond  (cond_e'(branch_cond)),
    .taken (cond_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= Q_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      nzcv_q     <= '0;
      bt_q       <= 1'b0;
      bpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      nzcv_q     <= nzcv_d;
      bt_q       <= bt_d;
      bpc_q      <= bpc_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = (state_q != Q_EMPTY);
  assign out_result    = head_q.result;
  assign out_rd_addr   = head_q.rd_addr;
  assign out_reg_write = head_q.reg_write;
  assign flags_q       = nzcv_q;
  assign branch_taken  = bt_q;
  assign branch_pc     = bpc_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Randomized self-checking bench for ex_result_stage against a queue/flag model.
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] alu_result;
  logic        alu_carry, alu_zero, alu_overflow, alu_negative;
  logic [1:0]  alu_op;
  logic        set_flags, reg_write, is_branch, flush;
  logic [3:0]  rd_addr, branch_cond;
  logic [31:0] branch_target;
  logic        out_valid, out_ready, out_reg_write, branch_taken;
  logic [31:0] out_result, branch_pc;
  logic [3:0]  out_rd_addr, flags_q;

  ex_result_stage #(.DATA_W(32), .RD_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_negative(alu_negative), .alu_op(alu_op),
    .set_flags(set_flags), .rd_addr(rd_addr), .reg_write(reg_write),
    .is_branch(is_branch), .branch_cond(branch_cond), .branch_target(branch_target),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
    .flags_q(flags_q), .branch_taken(branch_taken), .branch_pc(branch_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        rw;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  mflags;
  logic        mbt;
  logic [31:0] mpc;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ARM-style pairing: even code tests a predicate, odd code its inverse.
  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  task automatic model_reset();
    mq.delete();
    mflags = 4'b0000;
    mbt    = 1'b0;
    mpc    = 32'h0;
  endtask

  task automatic model_update();
    bit         acc, drn;
    logic [3:0] nf, ef;
    acc = in_valid && (mq.size() < 2) && !flush;
    drn = (mq.size() > 0) && out_ready;
    mbt = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      nf = {alu_negative, alu_zero, (alu_op < 2) ? {alu_carry, alu_overflow} : mflags[1:0]};
`ifdef EX_FLAGS_FWD_EN
      ef = set_flags ? nf : mflags;
`else
      ef = mflags;
`endif
      if (acc && is_branch && cond_ok(branch_cond, ef)) begin
        mbt = 1'b1;
        mpc = branch_target;
      end
      if (acc && set_flags) mflags = nf;
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back('{res: alu_result, rd: rd_addr, rw: reg_write});
    end
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_result", out_result, mq[0].res);
      chk("out_rd_addr", out_rd_addr, mq[0].rd);
      chk("out_reg_write", out_reg_write, mq[0].rw);
    end
    chk("flags_q", flags_q, mflags);
    chk("branch_taken", branch_taken, mbt);
    chk("branch_pc", branch_pc, mpc);
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit iv, input logic [31:0] res, input logic [3:0] nzcv,
                       input logic [1:0] op, input bit sf, input bit br,
                       input logic [3:0] cc, input logic [31:0] tgt,
                       input bit fl, input bit ordy);
    in_valid      = iv;
    alu_result    = res;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = nzcv;
    alu_op        = op;
    set_flags     = sf;
    is_branch     = br;
    branch_cond   = cc;
    branch_target = tgt;
    flush         = fl;
    out_ready     = ordy;
    rd_addr       = 4'($urandom_range(0, 15));
    reg_write     = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input bit ordy);
    drive(0, 32'h0, 4'h0, 2'd0, 0, 0, 4'h0, 32'h0, 0, ordy);
    tick();
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 1'b1);
    chk({pfx, "_out_valid"}, out_valid, 1'b0);
    chk({pfx, "_out_result"}, out_result, 32'h0);
    chk({pfx, "_out_rd_addr"}, out_rd_addr, 4'h0);
    chk({pfx, "_out_reg_write"}, out_reg_write, 1'b0);
    chk({pfx, "_flags_q"}, flags_q, 4'b0000);
    chk({pfx, "_branch_taken"}, branch_taken, 1'b0);
    chk({pfx, "_branch_pc"}, branch_pc, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 32'h0, 4'h0, 2'd0, 0, 0, 4'h0, 32'h0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // 0xFFFFFFFF + 1: result 0, Z and C set.
    drive(1, 32'h0, 4'b0110, 2'd0, 1, 0, 4'h0, 32'h0, 0, 1);
    tick();
    chk("add_wrap_result", out_result, 32'h0);
    chk("add_wrap_flags", flags_q, 4'b0110);

    // 0x7FFFFFFF + 1: N and V set.
    drive(1, 32'h8000_0000, 4'b1001, 2'd0, 1, 0, 4'h0, 32'h0, 0, 1);
    tick();
    chk("add_ovf_flags", flags_q, 4'b1001);

    // AND keeps C and V even though the ALU presents different values.
    drive(1, 32'h0, 4'b0110, 2'd0, 1, 0, 4'h0, 32'h0, 0, 1);
    tick();
    drive(1, 32'h1, 4'b0001, 2'd2, 1, 0, 4'h0, 32'h0, 0, 1);
    tick();
    chk("and_keep_cv", flags_q, 4'b0010);

    // Backpressure: two fill head+skid, third is held.
    idle(1); idle(1);
    drive(1, 32'hA1, 4'h0, 2'd2, 0, 0, 4'h0, 32'h0, 0, 0); tick();
    drive(1, 32'hA2, 4'h0, 2'd2, 0, 0, 4'h0, 32'h0, 0, 0); tick();
    chk("full_in_ready", in_ready, 1'b0);
    drive(1, 32'hA3, 4'h0, 2'd2, 0, 0, 4'h0, 32'h0, 0, 0); tick();
    chk("held_head", out_result, 32'hA1);
    drive(1, 32'hA3, 4'h0, 2'd2, 0, 0, 4'h0, 32'h0, 0, 1); tick();
    chk("drain_1", out_result, 32'hA2);
    drive(1, 32'hA3, 4'h0, 2'd2, 0, 0, 4'h0, 32'h0, 0, 1); tick();
    chk("drain_2", out_result, 32'hA3);
    idle(1);
    chk("drained_empty", out_valid, 1'b0);

    // Branches: Z=1, EQ taken, NE not.
    drive(1, 32'h0, 4'b0100, 2'd1, 1, 0, 4'h0, 32'h0, 0, 1); tick();
    drive(1, 32'h5, 4'h0, 2'd0, 0, 1, 4'h0, 32'h40, 0, 1); tick();
    chk("beq_taken", branch_taken, 1'b1);
    chk("beq_pc", branch_pc, 32'h40);
    drive(1, 32'h6, 4'h0, 2'd0, 0, 1, 4'h1, 32'h80, 0, 1); tick();
    chk("bne_pulse_end", branch_taken, 1'b0);
    chk("bne_pc_kept", branch_pc, 32'h40);

    // Flush while FULL with a flag-setting taken branch presented.
    drive(1, 32'hB1, 4'h0, 2'd0, 0, 0, 4'h0, 32'h0, 0, 0); tick();
    drive(1, 32'hB2, 4'h0, 2'd0, 0, 0, 4'h0, 32'h0, 0, 0); tick();
    drive(1, 32'hB3, 4'b1111, 2'd0, 1, 1, 4'hE, 32'hC0, 1, 0); tick();
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_flags", flags_q, 4'b0100);
    chk("flush_no_branch", branch_taken, 1'b0);

    // Random traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
      drive($urandom_range(0, 9) < 7, $urandom(), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)), $urandom(),
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Execute-result stage downstream of the 32-bit ALU. Registers each ALU result into the EX/MEM boundary through a 2-entry skid buffer with a valid/ready handshake. Maintains the architectural NZCV flag register and resolves conditional branches against those flags. Its output feeds the memory stage.

## Interface
Parameters:
- DATA_W, 32, datapath and branch-target width
- RD_W, 4, destination register address width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream transaction valid
- in_ready  out  1  stage can accept; registered
- alu_result  in  DATA_W  ALU Output
- alu_carry / alu_zero / alu_overflow / alu_negative  in  1 each  ALU flags
- alu_op  in  2  op that produced the result: 00 ADD, 01 SUB, 10 AND, 11 OR
- set_flags  in  1  update NZCV on acceptance
- rd_addr  in  RD_W  destination register
- reg_write  in  1  writeback enable
- is_branch  in  1  transaction is a conditional branch
- branch_cond  in  4  condition code
- branch_target  in  DATA_W  taken target
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_result / out_rd_addr / out_reg_write  out  DATA_W / RD_W / 1  head entry payload
- flags_q  out  4  NZCV, bit 3 = N
- branch_taken  out  1  one-cycle pulse
- branch_pc  out  DATA_W  target of the last taken branch

## Operation
- Acceptance: in_valid && in_ready && !flush.
- Queue states and transitions:
  - EMPTY: accept → ONE.
  - ONE: accept without drain → FULL; drain without accept → EMPTY; both → ONE with the head replaced.
  - FULL: drain → ONE, skid entry promoted to the head.
- Drain: out_valid && out_ready.
- Order is strict FIFO. No entry is lost or duplicated.
- Flag update on acceptance with set_flags:
  - N and Z are always written.
  - C and V are written only for ADD/SUB. AND/OR retain the previous C and V.
- Branch resolution on acceptance with is_branch:
  - The condition is evaluated against flags_q before this transaction's own update.
  - Codes: 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, A GE, B LT, C GT, D LE, E AL, F never.
- Every accepted transaction enters the queue, branches included.
- flush clears the queue (EMPTY) and drops any same-cycle input. It causes no flag update and no branch pulse. flags_q is unchanged.
- branch_taken does not flush the stage.
- Reset values:
  - in_ready=1, out_valid=0
  - out_result, out_rd_addr, out_reg_write = 0
  - flags_q=0000, branch_taken=0, branch_pc=0
  - queue EMPTY

## Timing
- Latency: 1 cycle from acceptance to out_valid/payload.
- Throughput: 1 per cycle while out_ready=1.
- in_ready falls the cycle after the queue reaches FULL and rises the cycle after FULL drains.
- flags_q and branch_taken/branch_pc update at the clock edge of acceptance, visible the next cycle.
- branch_taken is high for exactly one cycle per taken branch.
- Reset asserted mid-operation clears all state immediately. After release, operation resumes from EMPTY.

## Configuration
- EX_FLAGS_FWD_EN defined: a transaction with both set_flags and is_branch evaluates its condition against the flags it produces (same-cycle bypass).
- EX_FLAGS_FWD_EN undefined: that transaction evaluates against the prior flags_q.
- flags_q timing is identical in both builds.

## Structure
- Package ex_pkg holds:
  - alu_op_e
  - cond_e
  - flags_t (packed n, z, c, v)
  - ex_entry_t (result, rd_addr, reg_write)
  - the CC_* constants
- One combinational sub-module, cond_check: flags_t + cond_e → taken.

## Test plan
- Reset, accept 0xFFFFFFFF+1 (result 0, zero=1, carry=1, ADD, set_flags) → next cycle out_result=0, flags_q=0110.
- Accept 0x7FFFFFFF+1 (result 0x80000000, negative=1, overflow=1, ADD, set_flags) → flags_q=1001.
- With flags_q=0110, AND result 0x00000001 with set_flags → flags_q=0010 (C retained).
- out_ready=0, three consecutive in_valid → head+skid filled, in_ready low, third held. Raise out_ready → three results in order, no duplicate.
- flags_q Z=1, branch EQ target 0x40 → branch_taken one-cycle pulse, branch_pc=0x40. Cond NE → no pulse, branch_pc unchanged.
- Queue FULL, flush with in_valid=1 → next cycle out_valid=0, in_ready=1, flags_q unchanged, no branch pulse.
